// File: rtl/load_data_handle_pkg.sv
// Shared load-unit definitions: EXE-stage op codes, FSM encodings and
// the load-op decode helpers used by the load unit and its extender.
package load_data_handle_pkg;

  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;

  typedef enum logic [1:0] {
    LDH_IDLE = 2'd0,
    LDH_REQ  = 2'd1,
    LDH_WAIT = 2'd2,
    LDH_DROP = 2'd3
  } ldh_state_e;

  function automatic logic is_load_op(input logic [7:0] op);
    return (op == EXE_LB_OP) || (op == EXE_LBU_OP) || (op == EXE_LH_OP) ||
           (op == EXE_LHU_OP) || (op == EXE_LW_OP);
  endfunction

  // Byte loads can never fault on alignment.
  function automatic logic is_misaligned(input logic [7:0] op, input logic [1:0] a);
    logic mis;
    mis = 1'b0;
    if (op == EXE_LW_OP) mis = (a != 2'b00);
    else if ((op == EXE_LH_OP) || (op == EXE_LHU_OP)) mis = a[0];
    return mis;
  endfunction

endpackage

// File: rtl/load_data_handle_extend.sv
// Selects the addressed byte/halfword from a returned word and sign- or
// zero-extends it; purely combinational so a cache path can reuse it.
module load_extend
  import load_data_handle_pkg::*;
(
  input  logic [7:0]  op,
  input  logic [1:0]  byte_sel,
  input  logic [31:0] word,
  output logic [31:0] result
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = word[8*byte_sel +: 8];
    half_v = byte_sel[1] ? word[31:16] : word[15:0];
    case (op)
      EXE_LB_OP:  result = {{24{byte_v[7]}}, byte_v};
      EXE_LBU_OP: result = {24'h0, byte_v};
      EXE_LH_OP:  result = {{16{half_v[15]}}, half_v};
      EXE_LHU_OP: result = {16'h0, half_v};
      default:    result = word;
    endcase
  end

endmodule

// File: rtl/load_data_handle.sv
// Memory-stage load unit: alignment check, SRAM read handshake with
// pipeline stall, and registered extended result for write-back.
//
// state    | meaning
// ---------+-------------------------------------------------------
// LDH_IDLE | no load in flight; accepts a new load from EXE
// LDH_REQ  | mem_req asserted, waiting for mem_addr_ok
// LDH_WAIT | request accepted, waiting for mem_data_ok
// LDH_DROP | load flushed after accept; swallow its mem_data_ok
module load_data_handle
  import load_data_handle_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          ld_validE,
  input  logic [7:0]    alucontrolE,
  input  logic [DW-1:0] aluoutE,
  input  logic          flush,
  output logic          mem_req,
  output logic [DW-1:0] mem_addr,
  input  logic          mem_addr_ok,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_data_ok,
  output logic          stall_ld,
  output logic [DW-1:0] ReadDataM,
  output logic          rdata_valid,
  output logic          adel,
  output logic [DW-1:0] badvaddr
);

  ldh_state_e    state;
  logic [7:0]    op_q;
  logic [DW-1:0] addr_q;
  logic [DW-1:0] ext_result;
  logic          start;
  logic          mis;

  assign start    = ld_validE && is_load_op(alucontrolE) && !flush;
  assign mis      = is_misaligned(alucontrolE, aluoutE[1:0]);
  assign mem_addr = {addr_q[DW-1:2], 2'b00};
  assign stall_ld = (state != LDH_IDLE) || (start && !mis);

  load_extend u_load_extend (
    .op       (op_q),
    .byte_sel (addr_q[1:0]),
    .word     (mem_rdata),
    .result   (ext_result)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= LDH_IDLE;
      op_q        <= 8'h0;
      addr_q      <= '0;
      mem_req     <= 1'b0;
      ReadDataM   <= '0;
      rdata_valid <= 1'b0;
      adel        <= 1'b0;
      badvaddr    <= '0;
    end else begin
      rdata_valid <= 1'b0;
      adel        <= 1'b0;
      case (state)
        LDH_IDLE: begin
          if (start && mis) begin
            adel     <= 1'b1;
            badvaddr <= aluoutE;
          end else if (start) begin
            op_q    <= alucontrolE;
            addr_q  <= aluoutE;
            mem_req <= 1'b1;
            state   <= LDH_REQ;
          end
        end
        LDH_REQ: begin
          // data_ok only counts once the request itself has been accepted
          if (mem_addr_ok) begin
            mem_req <= 1'b0;
            if (mem_data_ok) begin
              state <= LDH_IDLE;
              if (!flush) begin
                ReadDataM   <= ext_result;
                rdata_valid <= 1'b1;
              end
            end else begin
              state <= flush ? LDH_DROP : LDH_WAIT;
            end
          end else if (flush) begin
            mem_req <= 1'b0;
            state   <= LDH_IDLE;
          end
        end
        LDH_WAIT: begin
          if (mem_data_ok) begin
            state <= LDH_IDLE;
            if (!flush) begin
              ReadDataM   <= ext_result;
              rdata_valid <= 1'b1;
            end
          end else if (flush) begin
            state <= LDH_DROP;
          end
        end
        LDH_DROP: begin
          if (mem_data_ok) state <= LDH_IDLE;
        end
        default: state <= LDH_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_data_handle.sv
// Directed bench for load_data_handle: extension cases, alignment fault,
// slow SRAM handshake, flush-drop and mid-load reset.
module tb_load_data_handle;
  import load_data_handle_pkg::*;

  logic        clk;
  logic        resetn;
  logic        ld_validE;
  logic [7:0]  alucontrolE;
  logic [31:0] aluoutE;
  logic        flush;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_addr_ok;
  logic [31:0] mem_rdata;
  logic        mem_data_ok;
  logic        stall_ld;
  logic [31:0] ReadDataM;
  logic        rdata_valid;
  logic        adel;
  logic [31:0] badvaddr;

  int n_chk  = 0;
  int n_pass = 0;

  load_data_handle #(.DW(32)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .ld_validE   (ld_validE),
    .alucontrolE (alucontrolE),
    .aluoutE     (aluoutE),
    .flush       (flush),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_addr_ok (mem_addr_ok),
    .mem_rdata   (mem_rdata),
    .mem_data_ok (mem_data_ok),
    .stall_ld    (stall_ld),
    .ReadDataM   (ReadDataM),
    .rdata_valid (rdata_valid),
    .adel        (adel),
    .badvaddr    (badvaddr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Zero-wait load: accept, REQ with addr_ok+data_ok, result next cycle.
  task automatic do_load(input string tag, input logic [7:0] op, input logic [31:0] addr,
                         input logic [31:0] rdata, input logic [31:0] exp);
    ld_validE = 1'b1; alucontrolE = op; aluoutE = addr;
    #1 chk({tag, " stall@accept"}, 32'(stall_ld), 32'd1);
    tick();
    ld_validE = 1'b0;
    chk({tag, " mem_req"}, 32'(mem_req), 32'd1);
    chk({tag, " mem_addr"}, mem_addr, {addr[31:2], 2'b00});
    mem_addr_ok = 1'b1; mem_data_ok = 1'b1; mem_rdata = rdata;
    tick();
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'h0;
    chk({tag, " rdata_valid"}, 32'(rdata_valid), 32'd1);
    chk({tag, " result"}, ReadDataM, exp);
    chk({tag, " req_low"}, 32'(mem_req), 32'd0);
    tick();
    chk({tag, " valid_pulse"}, 32'(rdata_valid), 32'd0);
  endtask

  initial begin
    resetn = 1'b0; ld_validE = 1'b0; alucontrolE = 8'h0; aluoutE = 32'h0; flush = 1'b0;
    mem_addr_ok = 1'b0; mem_rdata = 32'h0; mem_data_ok = 1'b0;
    #23 resetn = 1'b1;
    tick();
    chk("rst mem_req", 32'(mem_req), 32'd0);
    chk("rst stall", 32'(stall_ld), 32'd0);
    chk("rst rdata", ReadDataM, 32'h0);
    chk("rst valid", 32'(rdata_valid), 32'd0);
    chk("rst adel", 32'(adel), 32'd0);
    chk("rst badvaddr", badvaddr, 32'h0);

    do_load("lb3",  EXE_LB_OP,  32'h0000_1003, 32'h80FF_1234, 32'hFFFF_FF80);
    do_load("lbu3", EXE_LBU_OP, 32'h0000_1003, 32'h80FF_1234, 32'h0000_0080);
    do_load("lb1",  EXE_LB_OP,  32'h0000_1001, 32'h80FF_1234, 32'h0000_0012);
    do_load("lh2",  EXE_LH_OP,  32'h0000_2002, 32'h8001_7FFF, 32'hFFFF_8001);
    do_load("lhu2", EXE_LHU_OP, 32'h0000_2002, 32'h8001_7FFF, 32'h0000_8001);
    do_load("lh0",  EXE_LH_OP,  32'h0000_2000, 32'h8001_7FFF, 32'h0000_7FFF);

    // misaligned LW
    ld_validE = 1'b1; alucontrolE = EXE_LW_OP; aluoutE = 32'h0000_3001;
    #1 chk("adel stall", 32'(stall_ld), 32'd0);
    tick();
    ld_validE = 1'b0;
    chk("adel pulse", 32'(adel), 32'd1);
    chk("adel badvaddr", badvaddr, 32'h0000_3001);
    chk("adel no req", 32'(mem_req), 32'd0);
    tick();
    chk("adel clear", 32'(adel), 32'd0);
    chk("adel held", badvaddr, 32'h0000_3001);
    chk("adel no req2", 32'(mem_req), 32'd0);

    // misaligned LH
    ld_validE = 1'b1; alucontrolE = EXE_LH_OP; aluoutE = 32'h0000_2001;
    tick();
    ld_validE = 1'b0;
    chk("lh adel", 32'(adel), 32'd1);
    chk("lh badvaddr", badvaddr, 32'h0000_2001);
    tick();

    // LW with addr_ok on the 4th REQ cycle, data_ok two cycles later
    ld_validE = 1'b1; alucontrolE = EXE_LW_OP; aluoutE = 32'h0000_4000;
    tick();
    ld_validE = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("slow req held", 32'(mem_req), 32'd1);
      chk("slow addr", mem_addr, 32'h0000_4000);
      #1 chk("slow stall req", 32'(stall_ld), 32'd1);
      mem_addr_ok = (i == 3);
      tick();
    end
    mem_addr_ok = 1'b0;
    chk("slow req drop", 32'(mem_req), 32'd0);
    chk("slow stall wait", 32'(stall_ld), 32'd1);
    tick();
    chk("slow stall wait2", 32'(stall_ld), 32'd1);
    chk("slow no valid", 32'(rdata_valid), 32'd0);
    mem_data_ok = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_data_ok = 1'b0; mem_rdata = 32'h0;
    chk("slow valid", 32'(rdata_valid), 32'd1);
    chk("slow result", ReadDataM, 32'hDEAD_BEEF);
    chk("slow stall off", 32'(stall_ld), 32'd0);
    tick();

    // flush in WAIT, then a pending load must wait for the dropped data_ok
    ld_validE = 1'b1; alucontrolE = EXE_LB_OP; aluoutE = 32'h0000_5000;
    tick();
    ld_validE = 1'b0; mem_addr_ok = 1'b1;
    tick();
    mem_addr_ok = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    ld_validE = 1'b1; alucontrolE = EXE_LW_OP; aluoutE = 32'h0000_6000;
    #1 chk("drop stall", 32'(stall_ld), 32'd1);
    tick();
    chk("drop no req", 32'(mem_req), 32'd0);
    mem_data_ok = 1'b1; mem_rdata = 32'h5555_5555;
    tick();
    mem_data_ok = 1'b0; mem_rdata = 32'h0;
    chk("drop no valid", 32'(rdata_valid), 32'd0);
    chk("drop rdata kept", ReadDataM, 32'hDEAD_BEEF);
    chk("drop no req2", 32'(mem_req), 32'd0);
    chk("drop next stall", 32'(stall_ld), 32'd1);
    tick();
    ld_validE = 1'b0;
    chk("next req", 32'(mem_req), 32'd1);
    chk("next addr", mem_addr, 32'h0000_6000);
    mem_addr_ok = 1'b1; mem_data_ok = 1'b1; mem_rdata = 32'h1122_3344;
    tick();
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'h0;
    chk("next valid", 32'(rdata_valid), 32'd1);
    chk("next result", ReadDataM, 32'h1122_3344);
    tick();

    // reset while in WAIT
    ld_validE = 1'b1; alucontrolE = EXE_LBU_OP; aluoutE = 32'h0000_7001;
    tick();
    ld_validE = 1'b0; mem_addr_ok = 1'b1;
    tick();
    mem_addr_ok = 1'b0;
    #2 resetn = 1'b0;
    #1;
    chk("mrst req", 32'(mem_req), 32'd0);
    chk("mrst stall", 32'(stall_ld), 32'd0);
    chk("mrst rdata", ReadDataM, 32'h0);
    chk("mrst valid", 32'(rdata_valid), 32'd0);
    chk("mrst badvaddr", badvaddr, 32'h0);
    chk("mrst addr", mem_addr, 32'h0);
    #1 resetn = 1'b1;
    tick();
    do_load("post-rst lbu", EXE_LBU_OP, 32'h0000_7001, 32'hAABB_CCDD, 32'h0000_00CC);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
